srm_irq_ctrl: RTL

- Interrupt controller for the SRM-Starter core. It sits directly upstream of the register file.
- Latches external interrupt edges and arbitrates them by fixed priority.
- At an instruction boundary, when the register file's interrupt-enable bit is set, it sequences entry into the handler:
  - pulses ir_tsf so the register file saves pc into r3;
  - pulses ks to force kernel mode;
  - issues a vector load to the PC unit.

---
 rtl/srm_pkg.sv | 17 +
 rtl/srm_prio_enc.sv | 23 ++
 rtl/srm_irq_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/srm_pkg.sv
// rtl/srm_pkg.sv - shared types and constants for the SRM-Starter interrupt entry path
package srm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        KSW  = 2'd2,
        JUMP = 2'd3
    } irq_state_t;

    // Register-file indices touched by the entry sequence (pc -> r3, kernel bit in status)
    localparam int REG_IR     = 3;
    localparam int REG_STATUS = 1;

    localparam int CAUSE_W = 4;

endpackage

// File: rtl/srm_prio_enc.sv
// rtl/srm_prio_enc.sv - lowest-index-wins priority encoder with valid flag
module srm_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srm_irq_ctrl.sv
// rtl/srm_irq_ctrl.sv - edge-latched, fixed-priority interrupt controller with handler entry sequencer
module srm_irq_ctrl
    import srm_pkg::*;
#(
    parameter int          NUM_IRQ       = 8,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter int          VECTOR_STRIDE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                int_en,
    input  logic                insn_bound,
    input  logic                mask_we,
    input  logic                clr_we,
    input  logic [NUM_IRQ-1:0]  wdata,
    output logic [NUM_IRQ-1:0]  mask,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [CAUSE_W-1:0]  cause,
    output logic                busy,
    output logic                ir_tsf,
    output logic                ks,
    output logic                vec_load,
    output logic [31:0]         vec_pc
);

    irq_state_t          state;
    irq_state_t          state_nxt;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  req;
    logic [NUM_IRQ-1:0]  clr_bits;
    logic [NUM_IRQ-1:0]  take_bits;
    logic [CAUSE_W-1:0]  sel;
    logic                sel_valid;
    logic                take;

    assign rise     = irq & ~irq_q;
    assign req      = pending & mask;
    assign clr_bits = clr_we ? wdata : '0;

    srm_prio_enc #(
        .W     (NUM_IRQ),
        .IDX_W (CAUSE_W)
    ) u_prio_enc (
        .req   (req),
        .idx   (sel),
        .valid (sel_valid)
    );

    // Arbitration only happens from IDLE; once committed the sequence runs to completion.
    assign take      = (state == IDLE) && int_en && insn_bound && sel_valid;
    assign take_bits = take ? (NUM_IRQ'(1) << sel) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SAVE;
            SAVE:    state_nxt = KSW;
            KSW:     state_nxt = JUMP;
            JUMP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            cause   <= '0;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq;
            // A fresh edge beats both a software clear and the arbitration clear.
            pending <= (pending & ~clr_bits & ~take_bits) | rise;
            if (mask_we) begin
                mask <= wdata;
            end
            if (take) begin
                cause <= sel;
            end
        end
    end

    // Outputs decode straight from the state register, so they drop the instant reset asserts.
    assign busy     = (state != IDLE);
    assign ir_tsf   = (state == SAVE);
    assign ks       = (state == KSW);
    assign vec_load = (state == JUMP);
    assign vec_pc   = vec_load ? (VECTOR_BASE + (32'(cause) * 32'(VECTOR_STRIDE))) : 32'h0;

endmodule
